// File: rtl/lru_tracker.sv
// -----------------------------------------------------------------------------
// lru_tracker
//
// Least-recently-used tracker over N_ITEMS request lines with a DEPTH-entry
// recency list (slot 0 = most recent). Accesses are stepped by an external
// tick strobe. A request is latched in IDLE and committed one clock later in
// UPDATE, independent of tick. A request that is still held afterwards is
// not counted again until every line has been released (HOLD).
//
// Optional feature macro: LRU_STATS_EN (adds saturating hit/miss counters).
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset, clears all state
//   tick      single-cycle step strobe
//   req       access requests, bit k requests item id k+1 (req[0] has priority)
//   resident  bit k high while id k+1 is in the list
//   mru_id    id in slot 0 (0 when empty)
//   lru_id    id in the deepest occupied slot (0 when empty)
//   full      every slot occupied
//   hit       one-cycle pulse, committed access was resident
//   miss      one-cycle pulse, committed access was not resident
//   evict     one-cycle pulse, a miss dropped a non-zero id
//   evict_id  dropped id, valid with evict, held otherwise
//   hit_cnt   (LRU_STATS_EN) saturating hit counter
//   miss_cnt  (LRU_STATS_EN) saturating miss counter
// -----------------------------------------------------------------------------
module lru_tracker #(
  parameter int N_ITEMS = 4,
  parameter int DEPTH   = 3,
`ifdef LRU_STATS_EN
  parameter int STATS_W = 8,
`endif
  localparam int IDX_W  = $clog2(N_ITEMS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [N_ITEMS-1:0] req,
  output logic [N_ITEMS-1:0] resident,
  output logic [IDX_W-1:0]   mru_id,
  output logic [IDX_W-1:0]   lru_id,
  output logic               full,
  output logic               hit,
  output logic               miss,
  output logic               evict,
  output logic [IDX_W-1:0]   evict_id
`ifdef LRU_STATS_EN
  ,
  output logic [STATS_W-1:0] hit_cnt,
  output logic [STATS_W-1:0] miss_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] ID_NONE = {IDX_W{1'b0}};

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   pend_q, pend_d;
  logic [IDX_W-1:0]   slot_q [DEPTH];
  logic [IDX_W-1:0]   slot_d [DEPTH];
  logic [N_ITEMS-1:0] resident_q, resident_d;
  logic [IDX_W-1:0]   mru_q, mru_d;
  logic [IDX_W-1:0]   lru_q, lru_d;
  logic               full_q, full_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               evict_q, evict_d;
  logic [IDX_W-1:0]   evict_id_q, evict_id_d;

  logic [IDX_W-1:0]   pick_s;
  logic [DEPTH-1:0]   hit_vec_s;
  logic [DEPTH-1:0]   shift_s;
  logic               hit_s;
  logic [IDX_W-1:0]   shifted_s [DEPTH];

  // Pick the lowest-numbered active request line as the candidate id.
  always_comb begin
    pick_s = ID_NONE;
    for (int k = N_ITEMS - 1; k >= 0; k--) begin
      pick_s = req[k] ? IDX_W'(k + 1) : pick_s;
    end
  end

  // Look up the pending id and build the list as it looks after the commit.
  always_comb begin
    logic acc_s;
    acc_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = (slot_q[i] == pend_q) && (pend_q != ID_NONE);
    end
    // shift_s[i] is set when the hit lies at slot i or deeper, so slot i must
    // take its upper neighbour; on a miss every slot shifts.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc_s      = acc_s | hit_vec_s[i];
      shift_s[i] = acc_s;
    end
    hit_s        = |hit_vec_s;
    shifted_s[0] = pend_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (!hit_s || shift_s[i]) begin
        shifted_s[i] = slot_q[i-1];
      end else begin
        shifted_s[i] = slot_q[i];
      end
    end
  end

  // FSM next state, list update and event pulses.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    slot_d     = slot_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    evict_d    = 1'b0;
    evict_id_d = evict_id_q;
    case (state_q)
      ST_INIT: begin
        if (tick) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (tick && (|req)) begin
          pend_d  = pick_s;
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        // Commit does not wait for tick.
        state_d = ST_HOLD;
        slot_d  = shifted_s;
        hit_d   = hit_s;
        miss_d  = !hit_s;
        if (!hit_s && (slot_q[DEPTH-1] != ID_NONE)) begin
          evict_d    = 1'b1;
          evict_id_d = slot_q[DEPTH-1];
        end else begin
          evict_d    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (tick && (req == {N_ITEMS{1'b0}})) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Status views of the next list, registered together with the list itself.
  always_comb begin
    resident_d = {N_ITEMS{1'b0}};
    lru_d      = ID_NONE;
    full_d     = 1'b1;
    mru_d      = slot_d[0];
    for (int i = 0; i < DEPTH; i++) begin
      // Occupied slots are contiguous, so the last non-zero one is the LRU.
      lru_d  = (slot_d[i] != ID_NONE) ? slot_d[i] : lru_d;
      full_d = full_d & (slot_d[i] != ID_NONE);
    end
    for (int k = 0; k < N_ITEMS; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        resident_d[k] = resident_d[k] | (slot_d[i] == IDX_W'(k + 1));
      end
    end
  end

  // State, list and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      pend_q     <= ID_NONE;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= ID_NONE;
      end
      resident_q <= {N_ITEMS{1'b0}};
      mru_q      <= ID_NONE;
      lru_q      <= ID_NONE;
      full_q     <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      evict_q    <= 1'b0;
      evict_id_q <= ID_NONE;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      slot_q     <= slot_d;
      resident_q <= resident_d;
      mru_q      <= mru_d;
      lru_q      <= lru_d;
      full_q     <= full_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      evict_q    <= evict_d;
      evict_id_q <= evict_id_d;
    end
  end

  assign resident = resident_q;
  assign mru_id   = mru_q;
  assign lru_id   = lru_q;
  assign full     = full_q;
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign evict    = evict_q;
  assign evict_id = evict_id_q;

`ifdef LRU_STATS_EN
  logic [STATS_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STATS_W-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters advanced on the same edge that raises the pulse.
  always_comb begin
    if (hit_d && (hit_cnt_q != {STATS_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + STATS_W'(1);
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (miss_d && (miss_cnt_q != {STATS_W{1'b1}})) begin
      miss_cnt_d = miss_cnt_q + STATS_W'(1);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Statistic counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= {STATS_W{1'b0}};
      miss_cnt_q <= {STATS_W{1'b0}};
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_lru_tracker.sv
// -----------------------------------------------------------------------------
// tb_lru_tracker
//
// Scoreboard bench for lru_tracker (default parameters). Each access pushes
// the predicted post-commit view from a queue-based recency model; a monitor
// on the falling edge pops and compares whenever an event pulse is seen.
// Build with LRU_STATS_EN defined to also exercise the statistic counters.
// -----------------------------------------------------------------------------
module tb_lru_tracker;

  localparam int N = 4;
  localparam int D = 3;
  localparam int W = $clog2(N + 1);

  typedef struct {
    logic         hit;
    logic         miss;
    logic         evict;
    logic [W-1:0] evict_id;
    logic [W-1:0] mru;
    logic [W-1:0] lru;
    logic [N-1:0] resident;
    logic         full;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [N-1:0] req;
  logic [N-1:0] resident;
  logic [W-1:0] mru_id;
  logic [W-1:0] lru_id;
  logic         full;
  logic         hit;
  logic         miss;
  logic         evict;
  logic [W-1:0] evict_id;
`ifdef LRU_STATS_EN
  logic [7:0]   hit_cnt;
  logic [7:0]   miss_cnt;
`endif

  int   tests_run = 0;
  int   tests_failed = 0;
  int   lst[$];
  exp_t sb[$];
  int   exp_hits = 0;
  int   exp_misses = 0;

  lru_tracker #(.N_ITEMS(N), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .req      (req),
    .resident (resident),
    .mru_id   (mru_id),
    .lru_id   (lru_id),
    .full     (full),
    .hit      (hit),
    .miss     (miss),
    .evict    (evict),
    .evict_id (evict_id)
`ifdef LRU_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Recency model: queue front is most recent.
  function automatic exp_t model_access(input int id);
    exp_t e;
    int   pos = -1;
    int   dropped = 0;
    foreach (lst[i]) if (lst[i] == id) pos = i;
    e.hit = 1'b0; e.miss = 1'b0; e.evict = 1'b0; e.evict_id = '0;
    if (pos >= 0) begin
      lst.delete(pos);
      lst.push_front(id);
      e.hit = 1'b1;
      exp_hits++;
    end else begin
      lst.push_front(id);
      if (lst.size() > D) dropped = lst.pop_back();
      e.miss = 1'b1;
      exp_misses++;
      e.evict = (dropped != 0);
      e.evict_id = W'(dropped);
    end
    e.resident = '0;
    foreach (lst[i]) e.resident[lst[i]-1] = 1'b1;
    e.mru  = W'(lst[0]);
    e.lru  = W'(lst[lst.size()-1]);
    e.full = (lst.size() == D);
    return e;
  endfunction

  function automatic int lowest_id(input logic [N-1:0] r);
    int id = 0;
    for (int k = N - 1; k >= 0; k--) if (r[k]) id = k + 1;
    return id;
  endfunction

  // Monitor: every event pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && (hit || miss || evict)) begin
      if (sb.size() == 0) begin
        check_val("spurious_pulse", {29'd0, hit, miss, evict}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("hit", 32'(hit), 32'(e.hit));
        check_val("miss", 32'(miss), 32'(e.miss));
        check_val("evict", 32'(evict), 32'(e.evict));
        if (e.evict) check_val("evict_id", 32'(evict_id), 32'(e.evict_id));
        check_val("resident", 32'(resident), 32'(e.resident));
        check_val("mru_id", 32'(mru_id), 32'(e.mru));
        check_val("lru_id", 32'(lru_id), 32'(e.lru));
        check_val("full", 32'(full), 32'(e.full));
      end
    end
  end

  task automatic cyc(input logic t, input logic [N-1:0] r);
    tick = t;
    req  = r;
    @(posedge clk);
    #1;
  endtask

  // Capture on tick, commit on next edge, release on a tick.
  task automatic do_access(input logic [N-1:0] r);
    sb.push_back(model_access(lowest_id(r)));
    cyc(1'b1, r);
    cyc(1'b0, r);
    cyc(1'b1, '0);
    tick = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_resident"}, 32'(resident), 32'd0);
    check_val({tag, "_mru"}, 32'(mru_id), 32'd0);
    check_val({tag, "_lru"}, 32'(lru_id), 32'd0);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_pulses"}, {29'd0, hit, miss, evict}, 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    req  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, '0);
    cyc(1'b1, '0);
    tick = 1'b0;
    check_idle_zero("reset");

    // Fill: 1,2,3 -> [3,2,1], then hit on 1 and evicting miss on 4.
    do_access(4'b0001);
    do_access(4'b0010);
    do_access(4'b0100);
    check_val("fill_resident", 32'(resident), 32'h7);
    check_val("fill_full", 32'(full), 32'd1);
    do_access(4'b0001);
    check_val("hit_lru", 32'(lru_id), 32'd2);
    do_access(4'b1000);
    check_val("evict_resident", 32'(resident), 32'hD);
    check_val("evict_id_held", 32'(evict_id), 32'd2);

    // req without tick in IDLE is ignored.
    cyc(1'b0, 4'b0001);
    cyc(1'b0, 4'b0001);
    cyc(1'b0, '0);

    // Held multi-line request with tick high throughout: one access only.
    sb.push_back(model_access(2));
    repeat (7) cyc(1'b1, 4'b0110);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0010);
    cyc(1'b1, '0);
    tick = 1'b0;
    check_val("hold_mru", 32'(mru_id), 32'd2);
    check_val("hold_sb_drained", 32'(sb.size()), 32'd0);

    // Random accesses.
    for (int n = 0; n < 12; n++) begin
      do_access(N'($urandom_range(1, 15)));
    end

    // Reset between capture and commit: no pulse, everything cleared.
    cyc(1'b1, 4'b0001);
    rst = 1'b1;
    #1;
    check_idle_zero("rst_update");
    @(posedge clk);
    #1;
    rst = 1'b0;
    lst.delete();
    check_idle_zero("rst_after");
    // First tick after reset only leaves INIT, so this request is not taken.
    cyc(1'b1, 4'b0001);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_idle_zero("init_step");
    do_access(4'b0100);
    check_val("recover_mru", 32'(mru_id), 32'd3);

`ifdef LRU_STATS_EN
    // Misses only: always request an id the model says is absent.
    for (int n = 0; n < 300; n++) begin
      int pick = 0;
      for (int k = N; k >= 1; k--) begin
        bit found = 1'b0;
        foreach (lst[i]) if (lst[i] == k) found = 1'b1;
        if (!found) pick = k;
      end
      do_access(N'(1 << (pick - 1)));
    end
    check_val("miss_cnt_sat", 32'(miss_cnt), 32'((exp_misses > 255) ? 255 : exp_misses));
    check_val("hit_cnt", 32'(hit_cnt), 32'((exp_hits > 255) ? 255 : exp_hits));
`endif

    cyc(1'b0, '0);
    cyc(1'b0, '0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lru_tracker.md
Name: lru_tracker

Overview:
Parametrised least-recently-used tracker: N_ITEMS request lines, DEPTH-entry recency list, true move-to-front on hit, no duplicate entries.
- Reports resident set, MRU/LRU ids, hit/miss/evict events.
- Steps on an external tick strobe from the timer block, so slow button inputs are stepped at the debounced rate.
- Each held request counts as a single access until released.

Parameters:
N_ITEMS, 4, number of trackable items / request lines (>=2)
DEPTH, 3, recency list entries (1..N_ITEMS)
IDX_W, $clog2(N_ITEMS+1), derived localparam; width of an item id (id 0 = empty slot)
STATS_W, 8, width of statistic counters (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high; clears all state
tick  in  1  single-cycle step strobe from timer; FSM advances only on tick, except the UPDATE commit
req  in  N_ITEMS  access requests; bit k requests item id k+1
resident  out  N_ITEMS  bit k high while id k+1 is in the list
mru_id  out  IDX_W  id in slot 0 (0 if empty)
lru_id  out  IDX_W  id in the highest occupied slot (0 if list empty)
full  out  1  all DEPTH slots non-zero
hit  out  1  one-cycle pulse: committed access was already resident
miss  out  1  one-cycle pulse: committed access was not resident
evict  out  1  one-cycle pulse: a miss dropped a non-zero id from slot DEPTH-1
evict_id  out  IDX_W  dropped id, valid with evict, held otherwise

Behaviour:
- Reset (async): list all zero, FSM=INIT, all outputs 0, pending id 0.
- Storage: slot[0..DEPTH-1] of IDX_W bits; slot 0 = MRU. Occupied slots are contiguous from slot 0.
- FSM states: INIT, IDLE, UPDATE, HOLD.
  - INIT: on tick -> IDLE.
  - IDLE: on tick with |req -> latch pending id = lowest set bit index + 1 (priority req[0]), -> UPDATE. Without tick, req is ignored.
  - UPDATE: next clk edge unconditionally (tick not required) commits the access -> HOLD.
  - HOLD: on tick with req==0 -> IDLE. A held or changed req is ignored until all lines are released.
- Commit, hit (pending id at slot p):
  - slots 0..p-1 shift down one; slot[0]=id; deeper slots unchanged.
  - hit=1. Hit at p=0 leaves order unchanged but still pulses hit.
- Commit, miss:
  - all slots shift down one; slot[0]=id; old slot[DEPTH-1] is dropped.
  - miss=1. If the dropped id != 0: evict=1, evict_id=dropped id.
- Output timing: resident, mru_id, lru_id and full are registered and reflect the new list on the cycle after the commit edge. hit/miss/evict are asserted for exactly that one cycle.
- Never both hit and miss. evict only with miss. evict never while the list is not full before the commit.
- Invariants: no id appears twice; popcount(resident) == number of non-zero slots <= DEPTH.
- DEPTH==1: every access to a different id evicts the previous one.
- tick held high continuously: FSM steps every cycle; a req still held is not re-counted (HOLD).
- Reset asserted in any state, including UPDATE: the commit is abandoned and the list is cleared immediately.

Optional Feature:
LRU_STATS_EN defined:
- Adds ports hit_cnt and miss_cnt (out, STATS_W each).
- Each increments on its pulse and saturates at all-ones.
- Both cleared by rst.
LRU_STATS_EN undefined:
- Ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, tick x2, no req -> resident=0000, mru_id=0, lru_id=0, full=0, no pulses.
- Defaults; access ids 1,2,3 (each: req on tick, release, tick) -> after 3rd: slots [3,2,1], resident=0111, full=1, three miss pulses, no evict.
- Then access 1 -> hit pulse, slots [1,3,2], lru_id=2, resident unchanged. Then access 4 -> miss + evict, evict_id=2, slots [4,1,3], resident=1101.
- req=0110 on tick -> id 2 chosen; hold req for 5 ticks -> exactly one access committed, FSM stays in HOLD until req=0 on a tick.
- rst pulsed mid-UPDATE (between capture and commit) -> no hit/miss pulse, all outputs 0, FSM=INIT; LRU_STATS_EN build: 300 misses with STATS_W=8 -> miss_cnt saturates at 255.
